// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and lane-positioned data for stores,
// lane extraction plus sign/zero extension for loads. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Store path: replicate right-aligned data across lanes, enable only the addressed bytes.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'd0;
        case (size)
            SIZE_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                be         = 4'b0000;
                wdata_lane = 32'd0;
            end
        endcase
    end

    // Load path: pick the addressed lane, then extend according to is_unsigned.
    always_comb begin
        load_byte = word[8*addr_lo +: 8];
        load_half = addr_lo[1] ? word[31:16] : word[15:0];
        rdata_ext = 32'd0;
        case (size)
            SIZE_BYTE: rdata_ext = {{24{load_byte[7] & ~is_unsigned}}, load_byte};
            SIZE_HALF: rdata_ext = {{16{load_half[15] & ~is_unsigned}}, load_half};
            SIZE_WORD: rdata_ext = word;
            default:   rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory behind a valid/ready request/response handshake.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// the sender holds its payload stable until that edge; the response holds until accepted.
// Accesses commit (store write / load capture) on the edge that enters RESP.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int LATENCY         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_unsigned;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [1:0]            cur_size;
    logic                  cur_unsigned;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic                  cur_err;
    logic [IDX_W-1:0]      cur_idx;

    logic                  accept;
    logic                  commit;
    logic                  handshake;

    logic [3:0]            be;
    logic [31:0]           wdata_lane;
    logic [31:0]           rdata_ext;
    logic [31:0]           mem_word;

    logic [31:0]           mem [MEM_DEPTH_WORDS];

    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dbg_state  = state;
    assign accept     = req_valid && req_ready;
    assign handshake  = resp_valid && resp_ready;
    assign commit     = (state != RESP) && (state_next == RESP);

    // With LATENCY = 1 the commit edge is the acceptance edge, so use the live request in IDLE.
    assign cur_addr     = (state == IDLE) ? req_addr     : lat_addr;
    assign cur_we       = (state == IDLE) ? req_we       : lat_we;
    assign cur_size     = (state == IDLE) ? req_size     : lat_size;
    assign cur_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
    assign cur_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
    assign cur_idx      = cur_addr[IDX_W+1:2];
    assign mem_word     = mem[cur_idx];

    // Reject reserved size, misaligned half/word, and word indices beyond the array.
    always_comb begin
        cur_err = 1'b0;
        if (cur_size == SIZE_RSVD)                             cur_err = 1'b1;
        if (cur_size == SIZE_HALF && cur_addr[0])              cur_err = 1'b1;
        if (cur_size == SIZE_WORD && cur_addr[1:0] != 2'b00)   cur_err = 1'b1;
        if ((cur_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH_WORDS))  cur_err = 1'b1;
    end

    mem_lane_align u_align (
        .size        (cur_size),
        .addr_lo     (cur_addr[1:0]),
        .is_unsigned (cur_unsigned),
        .wdata       (cur_wdata[31:0]),
        .word        (mem_word),
        .be          (be),
        .wdata_lane  (wdata_lane),
        .rdata_ext   (rdata_ext)
    );

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: IDLE -> WAIT (counting down) -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) state_next = RESP;
                else           cnt_next   = cnt - 1'b1;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, captured on the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr     <= '0;
            lat_we       <= 1'b0;
            lat_size     <= SIZE_BYTE;
            lat_unsigned <= 1'b0;
            lat_wdata    <= '0;
        end else if (accept) begin
            lat_addr     <= req_addr;
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
        end
    end

    // Response payload: captured at commit, held through backpressure, cleared after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (commit) begin
            resp_rdata <= (cur_err || cur_we) ? '0 : DATA_WIDTH'(rdata_ext);
            resp_err   <= cur_err;
        end else if (handshake) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    // Storage array (not reset): byte-enabled write of error-free stores at commit.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with LATENCY = 2 and 1024 words.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH_WORDS(1024), .LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    // Issue one request, wait for its response, accept it; returns data, error and latency.
    task automatic access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_addr = addr; req_we = we; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        checks++;
        if (!resp_valid) begin
            failures++;
            $display("FAIL resp_timeout addr=%h: no resp_valid within 20 cycles", addr);
        end
        @(negedge clk) resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_handshake addr=%h: req_ready=%b resp_valid=%b, need 1/0",
                     addr, req_ready, resp_valid);
        end
    endtask

    task automatic expect_resp(input string name, input logic [31:0] addr, input logic we,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(addr, we, size, uns, wdata, rd, er, lat);
        checks++;
        if (rd !== exp_rdata || er !== exp_err || lat !== 2) begin
            failures++;
            $display("FAIL %s: rdata=%h err=%b lat=%0d, need rdata=%h err=%b lat=2",
                     name, rd, er, lat, exp_rdata, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h err=%b, need 0/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_release: req_ready=%b state=%0d, need 1/0", req_ready, dbg_state);
        end
    endtask

    task automatic test_word();
        expect_resp("store_word_10", 32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        expect_resp("load_word_10",  32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_byte();
        expect_resp("store_byte_13",  32'h13, 1'b1, 2'b00, 1'b0, 32'h00000080, 32'h0, 1'b0);
        expect_resp("load_sbyte_13",  32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        expect_resp("load_ubyte_13",  32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
        expect_resp("load_word_after_byte", 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
        expect_resp("load_sbyte_10",  32'h10, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0);
        expect_resp("load_ubyte_11",  32'h11, 1'b0, 2'b00, 1'b1, 32'h0, 32'h000000BE, 1'b0);
    endtask

    task automatic test_half_and_errors();
        expect_resp("store_half_misaligned", 32'h11, 1'b1, 2'b01, 1'b0, 32'h1234, 32'h0, 1'b1);
        expect_resp("load_word_untouched",   32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
        expect_resp("load_shalf_12",         32'h12, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF80AD, 1'b0);
        expect_resp("load_uhalf_12",         32'h12, 1'b0, 2'b01, 1'b1, 32'h0, 32'h000080AD, 1'b0);
        expect_resp("load_word_misaligned",  32'h12, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_resp("load_size_reserved",    32'h10, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_resp("store_half_10",         32'h10, 1'b1, 2'b01, 1'b0, 32'hFFFF5A5A, 32'h0, 1'b0);
        expect_resp("load_word_after_half",  32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'h80AD5A5A, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [31:0] held_rdata;
        int guard;
        expect_resp("store_word_30_zero", 32'h30, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        req_addr = 32'h10; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        held_rdata = 32'h80AD5A5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== held_rdata || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b, need 1/%h/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready, held_rdata);
            end
            if (i == 1) begin
                req_addr = 32'h30; req_we = 1'b1; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: valid=%b ready=%b, need 0/1", resp_valid, req_ready);
        end
        expect_resp("ignored_store_absent", 32'h30, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        expect_resp("store_word_20_prior", 32'h20, 1'b1, 2'b10, 1'b0, 32'hAAAA5555, 32'h0, 1'b0);
        @(negedge clk);
        req_addr = 32'h20; req_we = 1'b1; req_size = 2'b10; req_wdata = 32'h11111111; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (dbg_state !== 2'd1) begin
            failures++;
            $display("FAIL wait_state: state=%0d, need 1", dbg_state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_op: ready=%b valid=%b rdata=%h err=%b state=%0d, need 0/0/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err, dbg_state);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        expect_resp("store_discarded", 32'h20, 1'b0, 2'b10, 1'b0, 32'h0, 32'hAAAA5555, 1'b0);
    endtask

    task automatic test_range();
        expect_resp("store_word_ffc", 32'hFFC, 1'b1, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0);
        expect_resp("load_word_ffc",  32'hFFC, 1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0);
        expect_resp("load_word_1000", 32'h1000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        expect_resp("store_byte_1000", 32'h1000, 1'b1, 2'b00, 1'b0, 32'hFF, 32'h0, 1'b1);
        expect_resp("load_word_0_alias", 32'h0, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        // Word 0 is written so the alias check after the out-of-range store has a known value.
        expect_resp("store_word_0", 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        test_word();
        test_byte();
        test_half_and_errors();
        test_backpressure();
        test_reset_mid_op();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
